// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues word reads over a request/grant
// port, buffers in-order returns and hands them to decode with valid/ready.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int          PW  = $clog2(DEPTH);
  localparam int          CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

  logic          rst_n_q;
  logic [31:0]   pc;

  // Instruction buffer: {instr, pc} pairs awaiting decode.
  logic [31:0]   buf_instr [DEPTH];
  logic [31:0]   buf_pc    [DEPTH];
  logic [PW-1:0] buf_rd;
  logic [PW-1:0] buf_wr;
  logic [CW-1:0] count;

  // Issued addresses, popped one per return so each word pairs with its pc.
  logic [31:0]   addr_q [DEPTH];
  logic [PW-1:0] addr_rd;
  logic [PW-1:0] addr_wr;
  logic [CW-1:0] outst;
  logic [CW-1:0] kill;

  logic [CW:0]   inflight;
  logic          grant;
  logic          ret;
  logic          keep;
  logic          pop;
  logic [31:0]   pc_nxt;
  logic [CW-1:0] outst_nxt;
  logic [CW-1:0] kill_nxt;
  logic [CW-1:0] count_nxt;

  logic          unused_pc_bits;
  assign unused_pc_bits = ^redirect_pc[1:0];

  // Both ports use strict valid/ready: a transfer happens on a rising edge
  // where valid and ready (gnt) are both high; while valid is high and the
  // transfer has not happened, the payload is held stable.
  assign imem_addr   = pc;
  assign instr_valid = (count != '0);
  assign instr       = buf_instr[buf_rd];
  assign instr_pc    = buf_pc[buf_rd];

  always_comb begin
    inflight  = {1'b0, outst} + {1'b0, count};
    imem_req  = rst_n_q && !redirect && (inflight < CAP);
    grant     = imem_req && imem_gnt;
    ret       = imem_rvalid && (outst != '0);
    keep      = ret && (kill == '0) && !redirect;
    pop       = instr_valid && instr_ready;
    outst_nxt = outst + CW'(grant) - CW'(ret);

    pc_nxt = pc;
    if (redirect) begin
      pc_nxt = {redirect_pc[31:2], 2'b00};
    end else if (grant) begin
      pc_nxt = pc + 32'd4;
    end

    // Every read still in flight after a redirect belongs to the old path.
    kill_nxt = kill;
    if (redirect) begin
      kill_nxt = outst_nxt;
    end else if (ret && (kill != '0)) begin
      kill_nxt = kill - CW'(1);
    end

    count_nxt = count;
    if (redirect) begin
      count_nxt = '0;
    end else begin
      count_nxt = count + CW'(keep) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    rst_n_q <= rst_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      count   <= '0;
      outst   <= '0;
      kill    <= '0;
      buf_rd  <= '0;
      buf_wr  <= '0;
      addr_rd <= '0;
      addr_wr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_instr[i] <= NOP;
        buf_pc[i]    <= RESET_PC;
        addr_q[i]    <= RESET_PC;
      end
    end else begin
      pc    <= pc_nxt;
      count <= count_nxt;
      outst <= outst_nxt;
      kill  <= kill_nxt;

      if (grant) begin
        addr_q[addr_wr] <= pc;
        addr_wr         <= addr_wr + PW'(1);
      end
      if (ret) begin
        addr_rd <= addr_rd + PW'(1);
      end

      if (keep) begin
        buf_instr[buf_wr] <= imem_rdata;
        buf_pc[buf_wr]    <= addr_q[addr_rd];
        buf_wr            <= buf_wr + PW'(1);
      end
      // A flush empties the buffer by catching the read pointer up.
      if (redirect) begin
        buf_rd <= buf_wr;
      end else if (pop) begin
        buf_rd <= buf_rd + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory model with adjustable latency, a consumer
// that checks every accepted instruction against an expected queue.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = 32'h0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];
  logic        ready_en = 1'b0;
  int          mem_lat = 1;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc = 0;
  int          out_cnt = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0040_0093;
      32'h0000_0004: return 32'h0050_0113;
      32'h0000_0008: return 32'hFFC0_0193;
      default:       return a ^ 32'hA500_0000;
    endcase
  endfunction

  function automatic logic [63:0] ent(input logic [31:0] a);
    return {a, mem_word(a)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d instructions never delivered, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Memory model: in-order returns mem_lat cycles after each grant.
  always @(posedge clk) begin
    logic [31:0] a;
    cyc = cyc + 1;
    if (!rst_n) begin
      pend_addr.delete();
      pend_due.delete();
      out_cnt = 0;
      imem_rvalid <= 1'b0;
    end else begin
      assert (!(imem_rvalid && out_cnt == 0))
        else $error("protocol: read return with no outstanding grant");
      if (imem_rvalid) out_cnt = out_cnt - 1;
      if (imem_req && imem_gnt) begin
        pend_addr.push_back(imem_addr);
        pend_due.push_back(cyc - 1 + mem_lat);
        out_cnt = out_cnt + 1;
      end
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        a = pend_addr.pop_front();
        void'(pend_due.pop_front());
        imem_rvalid <= 1'b1;
        imem_rdata  <= mem_word(a);
      end else begin
        imem_rvalid <= 1'b0;
      end
    end
  end

  // Consumer/monitor: accepts only while an expectation is queued.
  always @(negedge clk) begin
    logic [63:0] e;
    instr_ready = ready_en && (exp_q.size() > 0);
    if (rst_n && instr_valid && instr_ready) begin
      e = exp_q.pop_front();
      check("instr_pc", instr_pc, e[63:32]);
      check("instr", instr, e[31:0]);
    end
  end

  initial begin
    int k;
    rst_n       = 1'b0;
    imem_gnt    = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    // Reset held three cycles with the grant line high.
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("reset imem_req", {31'b0, imem_req}, 32'd0);
      check("reset instr_valid", {31'b0, instr_valid}, 32'd0);
      check("reset instr", instr, NOP);
      check("reset imem_addr", imem_addr, 32'h0);
      check("reset instr_pc", instr_pc, 32'h0);
    end

    for (int a = 0; a < 64; a += 4) exp_q.push_back(ent(32'(a)));
    ready_en = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("release cycle imem_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    check("first imem_req", {31'b0, imem_req}, 32'd1);
    check("first imem_addr", imem_addr, 32'h0);

    // Grant stall once the fetch address reaches 0x0C.
    k = 0;
    while (imem_addr != 32'h0000_000C && k < 100) begin
      @(negedge clk);
      k++;
    end
    imem_gnt = 1'b0;
    k = 0;
    while (!imem_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check("stall imem_req", {31'b0, imem_req}, 32'd1);
      check("stall imem_addr", imem_addr, 32'h0000_000C);
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    check("post-grant imem_addr", imem_addr, 32'h0000_0010);

    // Backpressure: decode stalls five cycles, head must match next expected.
    @(posedge clk);
    #1 ready_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (instr_valid && exp_q.size() > 0) begin
        check("held instr_pc", instr_pc, exp_q[0][63:32]);
        check("held instr", instr, exp_q[0][31:0]);
      end
    end
    check("backpressure imem_req", {31'b0, imem_req}, 32'd0);
    check("backpressure instr_valid", {31'b0, instr_valid}, 32'd1);
    @(posedge clk);
    #1 ready_en = 1'b1;
    wait_drain("stream drain");

    // Redirect with two reads outstanding on a 3-cycle memory.
    mem_lat = 3;
    repeat (6) @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    @(negedge clk);
    redirect = 1'b0;
    check("redirect R+1 instr_valid", {31'b0, instr_valid}, 32'd0);
    k = 0;
    while (!(out_cnt == 2 && !imem_rvalid) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("two reads outstanding", 32'(out_cnt), 32'd2);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    @(negedge clk);
    redirect = 1'b0;
    exp_q.push_back({32'h0000_0100, 32'hA500_0100});
    exp_q.push_back({32'h0000_0104, 32'hA500_0104});
    wait_drain("redirect 0x100 drain");

    // Misaligned target, then wrap at the top of the address space.
    mem_lat = 1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    @(negedge clk);
    check("misaligned imem_addr", imem_addr, 32'h0000_0100);
    check("misaligned instr_valid", {31'b0, instr_valid}, 32'd0);
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    check("wrap target imem_addr", imem_addr, 32'hFFFF_FFFC);
    redirect = 1'b0;
    exp_q.push_back({32'hFFFF_FFFC, 32'h5AFF_FFFC});
    exp_q.push_back({32'h0000_0000, 32'h0040_0093});
    exp_q.push_back({32'h0000_0004, 32'h0050_0113});
    wait_drain("wrap drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
